// File: rtl/vga_mode_sequencer_if.sv
// Request/status bundle between the processor-side requester and the VGA mode sequencer.
// The sync generator's iVS rides along since it paces every fade step.
interface vga_mode_sequencer_if #(
    parameter int MODE_W  = 3,
    parameter int LEVEL_W = 3,
    parameter int CNT_W   = 16
);
    logic               iVS;
    logic [MODE_W-1:0]  iMode_req;
    logic               iReq_valid;
    logic               oReq_ready;
    logic [MODE_W-1:0]  oMode;
    logic [LEVEL_W-1:0] oLevel;
    logic               oApply;
    logic               oBusy;
    logic [CNT_W-1:0]   oFrame_cnt;

    modport master (
        output iVS, iMode_req, iReq_valid,
        input  oReq_ready, oMode, oLevel, oApply, oBusy, oFrame_cnt
    );

    modport slave (
        input  iVS, iMode_req, iReq_valid,
        output oReq_ready, oMode, oLevel, oApply, oBusy, oFrame_cnt
    );
endinterface

// File: rtl/vga_mode_sequencer.sv
// Frame-synchronous screen-mode scheduler: a mode change is applied only while the
// picture is faded to black, stepping brightness once every FADE_FRAMES frames.
//
//   state    | meaning
//   STEADY   | full brightness, accepting requests
//   FADE_OUT | dimming one level per FADE_FRAMES frames
//   SWITCH   | one cycle at black: load the pending mode
//   FADE_IN  | brightening back up to full
module vga_mode_sequencer #(
    parameter int FADE_FRAMES = 4,
    parameter int LEVEL_W     = 3,
    parameter int MODE_W      = 3,
    parameter int CNT_W       = 16
) (
    input  logic                 iVGA_CLK,
    input  logic                 iRST_n,
    vga_mode_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {STEADY, FADE_OUT, SWITCH, FADE_IN} state_t;

    localparam logic [LEVEL_W-1:0] LMAX     = '1;
    localparam int                 DIV_W    = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FADE_FRAMES - 1);

    state_t             state, state_next;
    logic               vs_d;
    logic [DIV_W-1:0]   div;
    logic [LEVEL_W-1:0] level;
    logic [MODE_W-1:0]  mode;
    logic [MODE_W-1:0]  pending;
    logic               apply;
    logic [CNT_W-1:0]   frame_cnt;
    logic               ready;
    logic               busy;
    logic               tick;
    logic               fading;
    logic               step;
    logic               accept;

    assign tick   = vs_d & ~bus.iVS;
    assign fading = (state == FADE_OUT) || (state == FADE_IN);
    assign step   = fading && tick && (div == DIV_LAST);
    assign accept = ready && bus.iReq_valid;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) state <= STEADY;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            STEADY:   if (accept && (bus.iMode_req != mode)) state_next = FADE_OUT;
            FADE_OUT: if (step && (level == LEVEL_W'(1)))     state_next = SWITCH;
            SWITCH:   state_next = FADE_IN;
            FADE_IN:  if (step && (level == LMAX - LEVEL_W'(1))) state_next = STEADY;
            default:  state_next = STEADY;
        endcase
    end

    always_comb begin
        ready = (state == STEADY);
        busy  = (state != STEADY);
    end

    // div sits at 0 outside the fades, so a tick in the accept cycle never counts
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_d      <= 1'b1;
            div       <= '0;
            level     <= LMAX;
            mode      <= '0;
            pending   <= '0;
            apply     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vs_d  <= bus.iVS;
            apply <= (state == SWITCH);

            if (!fading)  div <= '0;
            else if (tick) div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);

            if (step) begin
                if (state == FADE_OUT) level <= level - LEVEL_W'(1);
                else                   level <= level + LEVEL_W'(1);
            end

            if (accept)            pending <= bus.iMode_req;
            if (state == SWITCH)   mode    <= pending;

            if (state == SWITCH)                   frame_cnt <= '0;
            else if (tick && (frame_cnt != '1))    frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    assign bus.oReq_ready = ready;
    assign bus.oBusy      = busy;
    assign bus.oMode      = mode;
    assign bus.oLevel     = level;
    assign bus.oApply     = apply;
    assign bus.oFrame_cnt = frame_cnt;
endmodule
